// File: rtl/control_principal_multiciclo_if.sv
// Control bundle between the multi-cycle main control FSM and the datapath.
// Carries the decoded opcode and memory handshake into the controller and
// every datapath enable/mux select back out. o_Illegal exists only when
// CTRL_ILLEGAL_TRAP_EN is defined.
interface control_principal_multiciclo_if #(
   parameter int NBITS_OPCODE = 6,
   parameter int NBITS_ALUOP  = 2,
   parameter int NBITS_STATE  = 4
);
   logic [NBITS_OPCODE-1:0] i_Opcode;
   logic                    i_MemReady;
   logic                    o_PCWrite;
   logic                    o_PCWriteCond;
   logic                    o_IorD;
   logic                    o_MemRead;
   logic                    o_MemWrite;
   logic                    o_IRWrite;
   logic                    o_MemtoReg;
   logic                    o_RegDst;
   logic                    o_RegWrite;
   logic                    o_ALUSrcA;
   logic [1:0]              o_ALUSrcB;
   logic [1:0]              o_PCSource;
   logic [NBITS_ALUOP-1:0]  o_ALUOp;
   logic [NBITS_STATE-1:0]  o_State;
`ifdef CTRL_ILLEGAL_TRAP_EN
   logic                    o_Illegal;
`endif

   // Controller side: consumes opcode/handshake, drives all controls.
   modport master (
      input  i_Opcode, i_MemReady,
      output o_PCWrite, o_PCWriteCond, o_IorD, o_MemRead, o_MemWrite,
             o_IRWrite, o_MemtoReg, o_RegDst, o_RegWrite, o_ALUSrcA,
             o_ALUSrcB, o_PCSource, o_ALUOp, o_State
`ifdef CTRL_ILLEGAL_TRAP_EN
      , output o_Illegal
`endif
   );

   // Datapath side: supplies opcode/handshake, receives all controls.
   modport slave (
      output i_Opcode, i_MemReady,
      input  o_PCWrite, o_PCWriteCond, o_IorD, o_MemRead, o_MemWrite,
             o_IRWrite, o_MemtoReg, o_RegDst, o_RegWrite, o_ALUSrcA,
             o_ALUSrcB, o_PCSource, o_ALUOp, o_State
`ifdef CTRL_ILLEGAL_TRAP_EN
      , input o_Illegal
`endif
   );
endinterface

// File: rtl/control_principal_multiciclo.sv
// Multi-cycle MIPS main control FSM.
// Sequences FETCH/DECODE/execute/memory/writeback for R, LW, SW, BEQ, J and
// ADDI, producing datapath enables, mux selects and the 2-bit ALUOp for the
// ALU control decoder. Memory accesses stall on i_MemReady.
// Optional feature macro CTRL_ILLEGAL_TRAP_EN: an unknown opcode traps into a
// HALT state (encoding 12) that raises o_Illegal and is left only by reset.
// Without it, unknown opcodes behave as NOPs (DECODE back to FETCH).
// While i_reset is high every output is held at 0 so no write can escape.
module control_principal_multiciclo #(
   parameter int NBITS_OPCODE = 6,
   parameter int NBITS_ALUOP  = 2,
   parameter int NBITS_STATE  = 4
) (
   input logic                            i_clk,
   input logic                            i_reset,
   control_principal_multiciclo_if.master ctrl
);

   localparam logic [NBITS_OPCODE-1:0] OP_R    = 6'b000000;
   localparam logic [NBITS_OPCODE-1:0] OP_LW   = 6'b100011;
   localparam logic [NBITS_OPCODE-1:0] OP_SW   = 6'b101011;
   localparam logic [NBITS_OPCODE-1:0] OP_BEQ  = 6'b000100;
   localparam logic [NBITS_OPCODE-1:0] OP_J    = 6'b000010;
   localparam logic [NBITS_OPCODE-1:0] OP_ADDI = 6'b001000;

   localparam logic [NBITS_ALUOP-1:0] ALUOP_ADD   = 2'b00;
   localparam logic [NBITS_ALUOP-1:0] ALUOP_SUB   = 2'b01;
   localparam logic [NBITS_ALUOP-1:0] ALUOP_FUNCT = 2'b10;

   typedef enum logic [NBITS_STATE-1:0] {
      FETCH     = 4'd0,
      DECODE    = 4'd1,
      MEM_ADDR  = 4'd2,
      MEM_READ  = 4'd3,
      MEM_WB    = 4'd4,
      MEM_WRITE = 4'd5,
      EXEC_R    = 4'd6,
      R_WB      = 4'd7,
      BRANCH    = 4'd8,
      JUMP      = 4'd9,
      ADDI_EX   = 4'd10,
      ADDI_WB   = 4'd11
`ifdef CTRL_ILLEGAL_TRAP_EN
      , HALT    = 4'd12
`endif
   } state_t;

   state_t state, state_next;

   logic                   pc_write, pc_write_cond, i_or_d, mem_read;
   logic                   mem_write, ir_write, mem_to_reg, reg_dst;
   logic                   reg_write, alu_src_a;
   logic [1:0]             alu_src_b, pc_source;
   logic [NBITS_ALUOP-1:0] alu_op;
   logic                   illegal;

   // State register; reset always lands in FETCH, aborting any instruction.
   always_ff @(posedge i_clk) begin
      if (i_reset) state <= FETCH;
      else         state <= state_next;
   end

   // Next-state decode and per-state control outputs (Moore, plus MemReady in FETCH).
   always_comb begin
      state_next    = FETCH;
      pc_write      = 1'b0;
      pc_write_cond = 1'b0;
      i_or_d        = 1'b0;
      mem_read      = 1'b0;
      mem_write     = 1'b0;
      ir_write      = 1'b0;
      mem_to_reg    = 1'b0;
      reg_dst       = 1'b0;
      reg_write     = 1'b0;
      alu_src_a     = 1'b0;
      alu_src_b     = 2'b00;
      pc_source     = 2'b00;
      alu_op        = ALUOP_ADD;
      illegal       = 1'b0;

      case (state)
         FETCH: begin
            // PC+4 is computed in the same cycle the instruction is read.
            mem_read   = 1'b1;
            alu_src_b  = 2'b01;
            ir_write   = ctrl.i_MemReady;
            pc_write   = ctrl.i_MemReady;
            state_next = ctrl.i_MemReady ? DECODE : FETCH;
         end
         DECODE: begin
            // Speculative branch target PC + (imm << 2) into ALUOut.
            alu_src_b = 2'b11;
            case (ctrl.i_Opcode)
               OP_LW, OP_SW: state_next = MEM_ADDR;
               OP_R:         state_next = EXEC_R;
               OP_BEQ:       state_next = BRANCH;
               OP_J:         state_next = JUMP;
               OP_ADDI:      state_next = ADDI_EX;
`ifdef CTRL_ILLEGAL_TRAP_EN
               default:      state_next = HALT;
`else
               default:      state_next = FETCH;
`endif
            endcase
         end
         MEM_ADDR: begin
            alu_src_a = 1'b1;
            alu_src_b = 2'b10;
            if (ctrl.i_Opcode == OP_LW)      state_next = MEM_READ;
            else if (ctrl.i_Opcode == OP_SW) state_next = MEM_WRITE;
            else                             state_next = FETCH;
         end
         MEM_READ: begin
            mem_read   = 1'b1;
            i_or_d     = 1'b1;
            state_next = ctrl.i_MemReady ? MEM_WB : MEM_READ;
         end
         MEM_WB: begin
            reg_write  = 1'b1;
            mem_to_reg = 1'b1;
            state_next = FETCH;
         end
         MEM_WRITE: begin
            mem_write  = 1'b1;
            i_or_d     = 1'b1;
            state_next = ctrl.i_MemReady ? FETCH : MEM_WRITE;
         end
         EXEC_R: begin
            alu_src_a  = 1'b1;
            alu_op     = ALUOP_FUNCT;
            state_next = R_WB;
         end
         R_WB: begin
            reg_write  = 1'b1;
            reg_dst    = 1'b1;
            state_next = FETCH;
         end
         BRANCH: begin
            // rs - rt drives zero; PC takes the target held in ALUOut.
            alu_src_a     = 1'b1;
            alu_op        = ALUOP_SUB;
            pc_write_cond = 1'b1;
            pc_source     = 2'b01;
            state_next    = FETCH;
         end
         JUMP: begin
            pc_write   = 1'b1;
            pc_source  = 2'b10;
            state_next = FETCH;
         end
         ADDI_EX: begin
            alu_src_a  = 1'b1;
            alu_src_b  = 2'b10;
            state_next = ADDI_WB;
         end
         ADDI_WB: begin
            reg_write  = 1'b1;
            state_next = FETCH;
         end
`ifdef CTRL_ILLEGAL_TRAP_EN
         HALT: begin
            // Trapped: no datapath activity until reset.
            illegal    = 1'b1;
            state_next = HALT;
         end
`endif
         default: state_next = FETCH;
      endcase
   end

   // Output drive; reset masks everything so no stray PC/RF/memory write escapes.
   always_comb begin
      ctrl.o_PCWrite     = pc_write      & ~i_reset;
      ctrl.o_PCWriteCond = pc_write_cond & ~i_reset;
      ctrl.o_IorD        = i_or_d        & ~i_reset;
      ctrl.o_MemRead     = mem_read      & ~i_reset;
      ctrl.o_MemWrite    = mem_write     & ~i_reset;
      ctrl.o_IRWrite     = ir_write      & ~i_reset;
      ctrl.o_MemtoReg    = mem_to_reg    & ~i_reset;
      ctrl.o_RegDst      = reg_dst       & ~i_reset;
      ctrl.o_RegWrite    = reg_write     & ~i_reset;
      ctrl.o_ALUSrcA     = alu_src_a     & ~i_reset;
      ctrl.o_ALUSrcB     = i_reset ? 2'b00 : alu_src_b;
      ctrl.o_PCSource    = i_reset ? 2'b00 : pc_source;
      ctrl.o_ALUOp       = i_reset ? ALUOP_ADD : alu_op;
      ctrl.o_State       = i_reset ? FETCH : state;
`ifdef CTRL_ILLEGAL_TRAP_EN
      ctrl.o_Illegal     = illegal & ~i_reset;
`endif
   end

`ifndef CTRL_ILLEGAL_TRAP_EN
   logic unused_illegal;
   assign unused_illegal = illegal;
`endif

endmodule
